// File: rtl/instr_ram_responder_pkg.sv
`default_nettype none
// =============================================================================
// Module : instr_ram_responder_pkg
// Brief  : NOP encoding and responder state encoding shared by the fetch responder.
// Rev    : 1.0
// =============================================================================
package instr_ram_responder_pkg;

    localparam logic [31:0] CORE_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } resp_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_ram_responder_sp_ram.sv
`default_nettype none
// =============================================================================
// Module : instr_ram_responder_sp_ram
// Brief  : Single-port synchronous-read RAM; contents are never reset.
// Rev    : 1.0
// =============================================================================
module instr_ram_responder_sp_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/instr_ram_responder.sv
`default_nettype none
// =============================================================================
// Module : instr_ram_responder
// Brief  : Instruction-fetch responder: boot-load the store, then serve fetches.
// Rev    : 1.0
// =============================================================================
module instr_ram_responder
    import instr_ram_responder_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int BOOT_LOAD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_ram_rd,
    input  logic [ADDR_W-1:0] instr_ram_addr,
    output logic [DATA_W-1:0] instr_ram_din,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              reload,
    output logic              core_hold,
    output logic [ADDR_W:0]   load_cnt,
    output logic              load_ovf
);

    localparam logic [ADDR_W:0]   DEPTH       = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DATA_W-1:0] NOP_WORD    = DATA_W'(CORE_NOP_INSTR);
    localparam resp_state_e       RESET_STATE = (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;

    resp_state_e       state_q, state_d;
    logic              ld_ready_q, ld_ready_d;
    logic              core_hold_q, core_hold_d;
    logic [ADDR_W:0]   load_cnt_q, load_cnt_d;
    logic              load_ovf_q, load_ovf_d;
    logic              din_sel_q, din_sel_d;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ld_xfer;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        load_ovf_d = load_ovf_q;
        din_sel_d  = din_sel_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = load_cnt_q[ADDR_W-1:0];
        // ld_ready_q is only ever high while in LOAD
        ld_xfer    = ld_valid & ld_ready_q;

        case (state_q)
            ST_LOAD: begin
                din_sel_d = 1'b0;
                if (ld_xfer) begin
                    if (load_cnt_q != DEPTH) begin
                        ram_we     = 1'b1;
                        load_cnt_d = load_cnt_q + 1'b1;
                    end else begin
                        load_ovf_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                din_sel_d = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                ram_addr = instr_ram_addr;
                if (reload) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                    load_ovf_d = 1'b0;
                    din_sel_d  = 1'b0;
                end else if (instr_ram_rd) begin
                    ram_re    = 1'b1;
                    din_sel_d = 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        ld_ready_d  = (state_d == ST_LOAD);
        core_hold_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESET_STATE;
            ld_ready_q  <= 1'b0;
            core_hold_q <= 1'b1;
            load_cnt_q  <= '0;
            load_ovf_q  <= 1'b0;
            din_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_ready_q  <= ld_ready_d;
            core_hold_q <= core_hold_d;
            load_cnt_q  <= load_cnt_d;
            load_ovf_q  <= load_ovf_d;
            din_sel_q   <= din_sel_d;
        end
    end

    instr_ram_responder_sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ld_data),
        .rdata (ram_rdata)
    );

    // RAM output register is only exposed once a read has landed in RUN
    assign instr_ram_din = din_sel_q ? ram_rdata : NOP_WORD;
    assign ld_ready      = ld_ready_q;
    assign core_hold     = core_hold_q;
    assign load_cnt      = load_cnt_q;
    assign load_ovf      = load_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_ram_responder.sv
`default_nettype none
// =============================================================================
// Module : tb_instr_ram_responder
// Brief  : Self-checking bench for the instruction-fetch responder.
// Rev    : 1.0
// =============================================================================
module tb_instr_ram_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic [12:0] exp_cnt;
        logic        exp_ready;
        logic        exp_hold;
    } ld_vec_t;

    typedef struct {
        logic        rd;
        logic [11:0] addr;
        logic        reload;
        logic [31:0] exp_din;
        logic        exp_hold;
    } fe_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rd = 1'b0;
    logic [11:0] addr = '0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        reload = 1'b0;
    logic [31:0] din;
    logic        ld_ready;
    logic        core_hold;
    logic [12:0] load_cnt;
    logic        load_ovf;

    logic        s_rd = 1'b0;
    logic [1:0]  s_addr = '0;
    logic        s_ld_valid = 1'b0;
    logic [31:0] s_ld_data = '0;
    logic        s_ld_last = 1'b0;
    logic        s_reload = 1'b0;
    logic [31:0] s_din;
    logic        s_ld_ready;
    logic        s_core_hold;
    logic [2:0]  s_load_cnt;
    logic        s_load_ovf;

    logic        b_reload = 1'b0;
    logic [31:0] b_din;
    logic        b_ld_ready;
    logic        b_core_hold;
    logic [2:0]  b_load_cnt;
    logic        b_load_ovf;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb [$];

    ld_vec_t     ld_tab [7];
    fe_vec_t     fe_tab [7];

    always #5 clk = ~clk;

    instr_ram_responder dut (
        .clk            (clk),
        .rst            (rst),
        .instr_ram_rd   (rd),
        .instr_ram_addr (addr),
        .instr_ram_din  (din),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .reload         (reload),
        .core_hold      (core_hold),
        .load_cnt       (load_cnt),
        .load_ovf       (load_ovf)
    );

    instr_ram_responder #(.ADDR_W(2)) dut_s (
        .clk            (clk),
        .rst            (rst),
        .instr_ram_rd   (s_rd),
        .instr_ram_addr (s_addr),
        .instr_ram_din  (s_din),
        .ld_valid       (s_ld_valid),
        .ld_ready       (s_ld_ready),
        .ld_data        (s_ld_data),
        .ld_last        (s_ld_last),
        .reload         (s_reload),
        .core_hold      (s_core_hold),
        .load_cnt       (s_load_cnt),
        .load_ovf       (s_load_ovf)
    );

    instr_ram_responder #(.ADDR_W(2), .BOOT_LOAD(0)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .instr_ram_rd   (1'b0),
        .instr_ram_addr (2'b00),
        .instr_ram_din  (b_din),
        .ld_valid       (1'b0),
        .ld_ready       (b_ld_ready),
        .ld_data        (32'h0),
        .ld_last        (1'b0),
        .reload         (b_reload),
        .core_hold      (b_core_hold),
        .load_cnt       (b_load_cnt),
        .load_ovf       (b_load_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [31:0] act);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            chk(name, act, sb.pop_front());
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are checked there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_word(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [11:0] a, input logic [31:0] exp);
        rd   = 1'b1;
        addr = a;
        sb.push_back(exp);
        tick();
        rd   = 1'b0;
        sb_check("fetch_din", din);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        ld_tab[0] = '{1'b1, 32'h11, 1'b0, 13'd1, 1'b1, 1'b1};
        ld_tab[1] = '{1'b0, 32'hEE, 1'b0, 13'd1, 1'b1, 1'b1};
        ld_tab[2] = '{1'b1, 32'h22, 1'b0, 13'd2, 1'b1, 1'b1};
        ld_tab[3] = '{1'b0, 32'hEE, 1'b1, 13'd2, 1'b1, 1'b1};
        ld_tab[4] = '{1'b1, 32'h33, 1'b0, 13'd3, 1'b1, 1'b1};
        ld_tab[5] = '{1'b1, 32'h44, 1'b1, 13'd4, 1'b0, 1'b1};
        ld_tab[6] = '{1'b0, 32'hEE, 1'b0, 13'd4, 1'b0, 1'b0};

        fe_tab[0] = '{1'b1, 12'd0, 1'b0, 32'h11, 1'b0};
        fe_tab[1] = '{1'b1, 12'd1, 1'b0, 32'h22, 1'b0};
        fe_tab[2] = '{1'b1, 12'd2, 1'b0, 32'h33, 1'b0};
        fe_tab[3] = '{1'b1, 12'd3, 1'b0, 32'h44, 1'b0};
        fe_tab[4] = '{1'b0, 12'd0, 1'b0, 32'h44, 1'b0};
        fe_tab[5] = '{1'b0, 12'd2, 1'b0, 32'h44, 1'b0};
        fe_tab[6] = '{1'b1, 12'd1, 1'b1, NOP,    1'b1};

        #1 rst = 1'b0;
        #1;
        chk("rst_din",       din,         NOP);
        chk("rst_ld_ready",  {31'b0, ld_ready},  32'd0);
        chk("rst_core_hold", {31'b0, core_hold}, 32'd1);
        chk("rst_load_cnt",  {19'b0, load_cnt},  32'd0);
        chk("rst_load_ovf",  {31'b0, load_ovf},  32'd0);
        chk("rst_b_hold",    {31'b0, b_core_hold}, 32'd1);

        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rel_ld_ready",  {31'b0, ld_ready},  32'd1);
        chk("rel_core_hold", {31'b0, core_hold}, 32'd1);
        chk("rel_din",       din,                NOP);
        chk("rel_load_cnt",  {19'b0, load_cnt},  32'd0);
        chk("rel_b_hold",    {31'b0, b_core_hold}, 32'd0);
        chk("rel_b_ready",   {31'b0, b_ld_ready},  32'd0);
        chk("rel_b_din",     b_din,                NOP);

        // Gapped load with the fetch port active; fetches must be ignored
        for (int i = 0; i < 7; i++) begin
            ld_valid = ld_tab[i].valid;
            ld_data  = ld_tab[i].data;
            ld_last  = ld_tab[i].last;
            rd       = 1'b1;
            addr     = 12'd0;
            tick();
            chk("load_cnt",   {19'b0, load_cnt},  {19'b0, ld_tab[i].exp_cnt});
            chk("load_ready", {31'b0, ld_ready},  {31'b0, ld_tab[i].exp_ready});
            chk("load_hold",  {31'b0, core_hold}, {31'b0, ld_tab[i].exp_hold});
            chk("load_din",   din,                NOP);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        rd       = 1'b0;

        for (int i = 0; i < 7; i++) begin
            rd     = fe_tab[i].rd;
            addr   = fe_tab[i].addr;
            reload = fe_tab[i].reload;
            sb.push_back(fe_tab[i].exp_din);
            tick();
            sb_check("run_din", din);
            chk("run_hold", {31'b0, core_hold}, {31'b0, fe_tab[i].exp_hold});
        end
        rd     = 1'b0;
        reload = 1'b0;
        chk("reload_cnt",   {19'b0, load_cnt}, 32'd0);
        chk("reload_ovf",   {31'b0, load_ovf}, 32'd0);
        chk("reload_ready", {31'b0, ld_ready}, 32'd1);

        // Partial new image; word 3 keeps the previous image's contents
        ld_word(32'hA1, 1'b0);
        ld_word(32'hA2, 1'b0);
        ld_word(32'hA3, 1'b1);
        chk("img2_cnt",   {19'b0, load_cnt}, 32'd3);
        chk("img2_drain", {31'b0, ld_ready}, 32'd0);
        tick();
        chk("img2_hold",  {31'b0, core_hold}, 32'd0);
        fetch(12'd0, 32'hA1);
        fetch(12'd1, 32'hA2);
        fetch(12'd2, 32'hA3);
        fetch(12'd3, 32'h44);

        // Asynchronous reset in the middle of a load
        reload = 1'b1;
        tick();
        reload = 1'b0;
        ld_word(32'hB1, 1'b0);
        ld_word(32'hB2, 1'b0);
        chk("mid_cnt", {19'b0, load_cnt}, 32'd2);
        #3 rst = 1'b0;
        #1;
        chk("async_hold",  {31'b0, core_hold}, 32'd1);
        chk("async_ready", {31'b0, ld_ready},  32'd0);
        chk("async_cnt",   {19'b0, load_cnt},  32'd0);
        chk("async_din",   din,                NOP);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rerel_ready", {31'b0, ld_ready}, 32'd1);
        ld_word(32'hC1, 1'b0);
        ld_word(32'hC2, 1'b0);
        ld_word(32'hC3, 1'b0);
        ld_word(32'hC4, 1'b1);
        tick();
        fetch(12'd0, 32'hC1);
        fetch(12'd1, 32'hC2);
        fetch(12'd2, 32'hC3);
        fetch(12'd3, 32'hC4);

        // Overflow on the 4-word instance: six words, last two dropped
        for (int i = 0; i < 6; i++) begin
            s_ld_valid = 1'b1;
            s_ld_data  = 32'hD0 + i;
            s_ld_last  = (i == 5);
            tick();
            chk("ovf_cnt", {29'b0, s_load_cnt}, (i < 4) ? i + 1 : 4);
            chk("ovf_flag", {31'b0, s_load_ovf}, (i >= 4) ? 32'd1 : 32'd0);
        end
        s_ld_valid = 1'b0;
        s_ld_last  = 1'b0;
        chk("ovf_drain_ready", {31'b0, s_ld_ready}, 32'd0);
        tick();
        chk("ovf_hold", {31'b0, s_core_hold}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            s_rd   = 1'b1;
            s_addr = a[1:0];
            sb.push_back(32'hD0 + a);
            tick();
            sb_check("ovf_din", s_din);
        end
        s_rd     = 1'b1;
        s_reload = 1'b1;
        tick();
        s_rd     = 1'b0;
        s_reload = 1'b0;
        chk("ovf_clr_flag", {31'b0, s_load_ovf},  32'd0);
        chk("ovf_clr_cnt",  {29'b0, s_load_cnt},  32'd0);
        chk("ovf_clr_din",  s_din,                NOP);
        chk("ovf_clr_hold", {31'b0, s_core_hold}, 32'd1);

        // Direct-run instance still honours reload
        b_reload = 1'b1;
        tick();
        b_reload = 1'b0;
        chk("b_reload_hold",  {31'b0, b_core_hold}, 32'd1);
        chk("b_reload_ready", {31'b0, b_ld_ready},  32'd1);
        chk("b_reload_cnt",   {29'b0, b_load_cnt},  32'd0);
        chk("b_reload_ovf",   {31'b0, b_load_ovf},  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
